// File: rtl/dac_i2c_arbiter_if.sv
// Requester-side bus of the DAC i2c arbiter: four level requests in, grant/done pulses
// and the completion status out.
interface dac_i2c_arbiter_if;
  logic [3:0]  Req;
  logic [3:0]  ReqRead;
  logic [27:0] ReqAddr;
  logic [63:0] ReqData;
  logic [3:0]  Grant;
  logic [3:0]  Done;
  logic [15:0] RdData;
  logic [1:0]  ErrOut;
  logic        Timeout;

  modport master (
    output Req, ReqRead, ReqAddr, ReqData,
    input  Grant, Done, RdData, ErrOut, Timeout
  );

  modport slave (
    input  Req, ReqRead, ReqAddr, ReqData,
    output Grant, Done, RdData, ErrOut, Timeout
  );
endinterface

// File: rtl/dac_i2c_arbiter.sv
// Round-robin arbiter that shares one DAC i2c loader among four requesters.
// It issues one transaction at a time and recovers the loader when a read stalls.
module dac_i2c_arbiter #(
  parameter int WRWAIT  = 40000,
  parameter int RDTMO   = 65535,
  parameter int RSTWAIT = 2048
) (
  input  logic              Clock,
  input  logic              Reset,
  dac_i2c_arbiter_if.slave  bus,
  output logic              o_Busy,
  output logic              o_DacStrobe,
  output logic              o_DacRead,
  output logic [15:0]       o_DacReg,
  output logic [6:0]        o_DacAddr,
  output logic              o_DacRstCmd,
  input  logic              i_DacStrobeOut,
  input  logic [15:0]       i_DacRegOut,
  input  logic [1:0]        i_DacError
);

  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_ISSUE   = 6'b000010,
    S_WAITW   = 6'b000100,
    S_WAITR   = 6'b001000,
    S_RECOVER = 6'b010000,
    S_FIN     = 6'b100000
  } state_t;

  localparam logic [16:0] CNT_MAX = '1;
  localparam logic [16:0] WR_END  = 17'(WRWAIT - 1);
  localparam logic [16:0] TMO_END = 17'(RDTMO - 1);
  localparam logic [16:0] RST_END = 17'(RSTWAIT - 1);

  state_t r_State, w_Next;

  logic [1:0]       r_Ptr, r_Gnt, w_Sel;
  logic             r_Op;
  logic [6:0]       r_Addr;
  logic [15:0]      r_Data, r_RdCap, r_RdData;
  logic [16:0]      r_Cnt;
  logic             r_SawLow, r_Tmo;
  logic [3:0]       r_Grant, r_Done;
  logic [1:0]       r_ErrOut;
  logic             r_Timeout, r_DacStrobe, r_DacRead, r_DacRstCmd;
  logic             w_Any, w_RdCmpl;
  logic [3:0][6:0]  w_Addrs;
  logic [3:0][15:0] w_Datas;

  assign w_Addrs  = bus.ReqAddr;
  assign w_Datas  = bus.ReqData;
  assign w_Any    = |bus.Req;
  // A high strobe only counts once a low has been seen since Issue.
  assign w_RdCmpl = i_DacStrobeOut && r_SawLow;

  // First active request at or after Ptr, searching upward with wrap.
  always_comb begin
    w_Sel = '0;
    for (int k = 3; k >= 0; k--)
      if (bus.Req[r_Ptr + 2'(k)]) w_Sel = r_Ptr + 2'(k);
  end

  always_ff @(posedge Clock) begin
    if (Reset) r_State <= S_IDLE;
    else       r_State <= w_Next;
  end

  always_comb begin
    w_Next = r_State;
    case (r_State)
      S_IDLE:    if (w_Any) w_Next = S_ISSUE;
      S_ISSUE:   w_Next = r_Op ? S_WAITR : S_WAITW;
      S_WAITW:   if (r_Cnt == WR_END) w_Next = S_FIN;
      S_WAITR:   if (w_RdCmpl) w_Next = S_FIN;
                 else if (r_Cnt == TMO_END) w_Next = S_RECOVER;
      S_RECOVER: if (r_Cnt == RST_END) w_Next = S_FIN;
      S_FIN:     w_Next = S_IDLE;
      default:   w_Next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_Ptr       <= '0;
      r_Gnt       <= '0;
      r_Op        <= 1'b0;
      r_Addr      <= '0;
      r_Data      <= '0;
      r_RdCap     <= '0;
      r_RdData    <= '0;
      r_Cnt       <= '0;
      r_SawLow    <= 1'b0;
      r_Tmo       <= 1'b0;
      r_Grant     <= '0;
      r_Done      <= '0;
      r_ErrOut    <= '0;
      r_Timeout   <= 1'b0;
      r_DacStrobe <= 1'b0;
      r_DacRead   <= 1'b0;
      r_DacRstCmd <= 1'b0;
    end else begin
      r_Grant     <= '0;
      r_Done      <= '0;
      r_DacStrobe <= 1'b0;
      r_DacRead   <= 1'b0;
      r_DacRstCmd <= 1'b0;
      if (r_Cnt != CNT_MAX) r_Cnt <= r_Cnt + 17'd1;
      case (r_State)
        S_IDLE: if (w_Any) begin
          r_Gnt   <= w_Sel;
          r_Grant <= 4'b0001 << w_Sel;
          r_Op    <= bus.ReqRead[w_Sel];
          r_Addr  <= w_Addrs[w_Sel];
          r_Data  <= w_Datas[w_Sel];
        end
        S_ISSUE: begin
          r_DacRead   <= r_Op;
          r_DacStrobe <= !r_Op;
          r_Cnt       <= '0;
          r_SawLow    <= 1'b0;
          r_Tmo       <= 1'b0;
        end
        S_WAITR: begin
          if (!i_DacStrobeOut) r_SawLow <= 1'b1;
          if (w_RdCmpl) r_RdCap <= i_DacRegOut;
          else if (r_Cnt == TMO_END) begin
            r_Tmo       <= 1'b1;
            r_Cnt       <= '0;
            r_DacRstCmd <= 1'b1;
          end
        end
        S_FIN: begin
          r_Done    <= 4'b0001 << r_Gnt;
          r_ErrOut  <= r_Tmo ? 2'b00 : i_DacError;
          r_Timeout <= r_Tmo;
          r_Ptr     <= r_Gnt + 2'd1;
          if (r_Op && !r_Tmo) r_RdData <= r_RdCap;
        end
        default: ;
      endcase
    end
  end

  assign bus.Grant   = r_Grant;
  assign bus.Done    = r_Done;
  assign bus.RdData  = r_RdData;
  assign bus.ErrOut  = r_ErrOut;
  assign bus.Timeout = r_Timeout;
  assign o_Busy      = (r_State != S_IDLE);
  assign o_DacStrobe = r_DacStrobe;
  assign o_DacRead   = r_DacRead;
  assign o_DacReg    = r_Data;
  assign o_DacAddr   = r_Addr;
  assign o_DacRstCmd = r_DacRstCmd;

endmodule

// File: tb/tb_dac_i2c_arbiter.sv
// Directed bench for dac_i2c_arbiter with shortened wait parameters.
module tb_dac_i2c_arbiter;
  localparam int WRWAIT  = 40;
  localparam int RDTMO   = 1500;
  localparam int RSTWAIT = 16;

  logic        Clock, Reset;
  logic        o_Busy, o_DacStrobe, o_DacRead, o_DacRstCmd;
  logic [15:0] o_DacReg;
  logic [6:0]  o_DacAddr;
  logic        i_DacStrobeOut;
  logic [15:0] i_DacRegOut;
  logic [1:0]  i_DacError;

  int n_err = 0;
  int n_chk = 0;

  dac_i2c_arbiter_if bus();

  dac_i2c_arbiter #(.WRWAIT(WRWAIT), .RDTMO(RDTMO), .RSTWAIT(RSTWAIT)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .bus            (bus.slave),
    .o_Busy         (o_Busy),
    .o_DacStrobe    (o_DacStrobe),
    .o_DacRead      (o_DacRead),
    .o_DacReg       (o_DacReg),
    .o_DacAddr      (o_DacAddr),
    .o_DacRstCmd    (o_DacRstCmd),
    .i_DacStrobeOut (i_DacStrobeOut),
    .i_DacRegOut    (i_DacRegOut),
    .i_DacError     (i_DacError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind 0: Grant, 1: Done, 2: DacRstCmd. n = edges until seen, or limit.
  task automatic wait_sig(input int kind, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if (kind == 0 && bus.Grant != 4'b0) break;
      if (kind == 1 && bus.Done != 4'b0) break;
      if (kind == 2 && o_DacRstCmd) break;
    end
  endtask

  task automatic set_req(input int idx, input logic rd, input logic [6:0] addr,
                         input logic [15:0] data);
    bus.ReqRead[idx]          = rd;
    bus.ReqAddr[7*idx +: 7]   = addr;
    bus.ReqData[16*idx +: 16] = data;
  endtask

  initial begin
    int n;
    logic saw;
    Reset = 1'b1;
    bus.Req = '0; bus.ReqRead = '0; bus.ReqAddr = '0; bus.ReqData = '0;
    i_DacStrobeOut = 1'b1; i_DacRegOut = 16'h0; i_DacError = 2'b00;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    chk("rst_busy",   o_Busy, 0);
    chk("rst_grant",  bus.Grant, 0);
    chk("rst_done",   bus.Done, 0);
    chk("rst_rddata", bus.RdData, 0);
    chk("rst_err_tmo", {bus.ErrOut, bus.Timeout}, 0);
    chk("rst_dac",    {o_DacStrobe, o_DacRead, o_DacRstCmd, o_DacReg, o_DacAddr}, 0);

    // Single write from requester 0; payload changes after Grant must not leak in.
    set_req(0, 1'b0, 7'h0C, 16'h0ABC);
    bus.Req = 4'b0001;
    tick();
    chk("w_grant", bus.Grant, 4'b0001);
    chk("w_busy",  o_Busy, 1);
    bus.Req = 4'b0000;
    set_req(0, 1'b1, 7'h7F, 16'hFFFF);
    tick();
    chk("w_strobe", {o_DacStrobe, o_DacRead}, 2'b10);
    chk("w_reg",    o_DacReg, 16'h0ABC);
    chk("w_addr",   o_DacAddr, 7'h0C);
    wait_sig(1, 200, n);
    chk("w_lat",  n + 1, WRWAIT + 2);
    chk("w_done", bus.Done, 4'b0001);
    chk("w_err",  {bus.ErrOut, bus.Timeout}, 0);
    chk("w_reg_held", o_DacReg, 16'h0ABC);
    tick();
    chk("w_idle", {o_Busy, bus.Done}, 0);

    // Write from requester 1 completing with a loader error.
    set_req(1, 1'b0, 7'h11, 16'h5555);
    i_DacError = 2'b10;
    bus.Req = 4'b0010;
    tick();
    chk("e_grant", bus.Grant, 4'b0010);
    bus.Req = 4'b0000;
    wait_sig(1, 200, n);
    chk("e_done", bus.Done, 4'b0010);
    chk("e_err",  bus.ErrOut, 2'b10);
    i_DacError = 2'b00;

    // Read from requester 2; strobe is stale-high at Issue, then low 1000 cycles.
    set_req(2, 1'b1, 7'h48, 16'h0000);
    bus.Req = 4'b0100;
    tick();
    chk("r_grant", bus.Grant, 4'b0100);
    bus.Req = 4'b0000;
    tick();
    chk("r_strobe", {o_DacStrobe, o_DacRead}, 2'b01);
    chk("r_addr",   o_DacAddr, 7'h48);
    i_DacStrobeOut = 1'b0;
    saw = 1'b0;
    repeat (1000) begin
      tick();
      if (bus.Done != 4'b0) saw = 1'b1;
    end
    chk("r_early_done", saw, 0);
    i_DacStrobeOut = 1'b1;
    i_DacRegOut = 16'h1234;
    wait_sig(1, 100, n);
    chk("r_lat",  n, 2);
    chk("r_done", bus.Done, 4'b0100);
    chk("r_data", bus.RdData, 16'h1234);
    chk("r_tmo",  {bus.ErrOut, bus.Timeout}, 0);
    i_DacRegOut = 16'hFFFF;
    tick();
    chk("r_data_hold", bus.RdData, 16'h1234);

    // Read from requester 3 with strobe never dropping: times out, loader reset.
    set_req(3, 1'b1, 7'h33, 16'h0000);
    i_DacError = 2'b11;
    bus.Req = 4'b1000;
    tick();
    chk("t_grant", bus.Grant, 4'b1000);
    bus.Req = 4'b0000;
    wait_sig(2, RDTMO + 100, n);
    chk("t_rst_lat", n, RDTMO + 1);
    wait_sig(1, RSTWAIT + 100, n);
    chk("t_done_lat", n, RSTWAIT + 1);
    chk("t_done",   bus.Done, 4'b1000);
    chk("t_tmo",    bus.Timeout, 1);
    chk("t_err",    bus.ErrOut, 2'b00);
    chk("t_rddata", bus.RdData, 16'h1234);
    i_DacError = 2'b00;

    // Fairness: all four requests held; Ptr is 0 here.
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 7'(i), 16'(i));
    bus.Req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_sig(0, 100, n);
      chk($sformatf("f_grant%0d", i), bus.Grant, 4'b0001 << (i % 4));
      if (i > 0) chk($sformatf("f_gap%0d", i), n, 1);
      wait_sig(1, 200, n);
      chk($sformatf("f_done%0d", i), bus.Done, 4'b0001 << (i % 4));
    end
    bus.Req = 4'b0000;
    tick();
    chk("f_idle", {o_Busy, bus.Grant}, 0);

    // Ptr is 1; a write from 1 moves it to 2, then Req=1011 must grant 3.
    bus.Req = 4'b0010;
    tick();
    bus.Req = 4'b0000;
    wait_sig(1, 200, n);
    tick();
    bus.Req = 4'b1011;
    tick();
    chk("s_grant", bus.Grant, 4'b1000);
    bus.Req = 4'b0000;
    wait_sig(1, 200, n);
    chk("s_done", bus.Done, 4'b1000);
    tick();

    // Ptr is 0; requester 2 writes while requester 0 pulses Req mid-transaction.
    bus.Req = 4'b0100;
    tick();
    bus.Req = 4'b0000;
    repeat (5) tick();
    bus.Req = 4'b0001;
    repeat (5) tick();
    bus.Req = 4'b0000;
    wait_sig(1, 200, n);
    chk("i_done", bus.Done, 4'b0100);
    repeat (3) tick();
    chk("i_ignored", {o_Busy, bus.Grant}, 0);

    // Ptr is 3; reset in the middle of requester 3's write.
    bus.Req = 4'b1000;
    tick();
    chk("x_grant", bus.Grant, 4'b1000);
    bus.Req = 4'b0000;
    repeat (10) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("x_busy", o_Busy, 0);
    chk("x_out",  {bus.Done, bus.Grant, o_DacReg}, 0);
    saw = 1'b0;
    repeat (WRWAIT + 5) begin
      tick();
      if (bus.Done != 4'b0) saw = 1'b1;
    end
    chk("x_no_done", saw, 0);
    bus.Req = 4'b1100;
    tick();
    chk("x_regrant", bus.Grant, 4'b0100);
    bus.Req = 4'b0000;
    wait_sig(1, 200, n);
    chk("x_done", bus.Done, 4'b0100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dac_i2c_arbiter.md
DAC_I2C_ARBITER -- requirements
Module: dac_i2c_arbiter

Interface
REQ-001 Parameter WRWAIT, default 40000: Clock cycles after issue before a write counts as complete.
REQ-002 Parameter RDTMO, default 65535: maximum Clock cycles to wait for read completion.
REQ-003 Parameter RSTWAIT, default 2048: Clock cycles to wait after a DacRstCmd pulse.
REQ-004 Clock  in  1  100 MHz system clock; all logic on its rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Req  in  4  per-requester level request; held high until Grant.
REQ-007 ReqRead  in  4  per-requester op: 1=read, 0=write.
REQ-008 ReqAddr  in  28  4 x 7-bit i2c addresses; requester i uses bits [7i+6:7i].
REQ-009 ReqData  in  64  4 x 16-bit write data; requester i uses bits [16i+15:16i].
REQ-010 Grant  out  4  one-hot, one-cycle pulse; the request has been accepted.
REQ-011 Done  out  4  one-hot, one-cycle pulse; the transaction has finished.
REQ-012 RdData  out  16  read result; valid from the Done pulse until the next Done.
REQ-013 ErrOut  out  2  DacError captured at completion; valid with Done.
REQ-014 Timeout  out  1  set with Done when a read timed out.
REQ-015 Busy  out  1  high in every state except Idle.
REQ-016 DacStrobe, DacRead  out  1 each  one-cycle start pulses to the DAC loader.
REQ-017 DacReg  out  16, DacAddr  out  7  payload to the loader; held stable from Issue to Fin.
REQ-018 DacRstCmd  out  1  one-cycle reset pulse to the loader's i2c state machine.
REQ-019 DacStrobeOut  in  1, DacRegOut  in  16, DacError  in  2  loader status and read data.

Function
REQ-020 States: Idle, Issue, WaitW, WaitR, Recover, Fin; encoding is one-hot.
- Idle: if any Req is high, the block selects the granted requester round-robin, starting at Ptr.
- Idle, same edge: latch the granted requester's op, address and data, pulse Grant, then go to Issue.
REQ-021 Issue lasts exactly 1 cycle: pulse DacRead if op=read, else DacStrobe, then go to WaitR or WaitW; clear the 17-bit counter Cnt.
REQ-022 WaitW: increment Cnt every cycle; when Cnt==WRWAIT-1, go to Fin.
REQ-023 WaitR, completion detection: set flag SawLow when DacStrobeOut is 0.
- Completion is the first cycle with DacStrobeOut==1 and SawLow==1; a stale high from a prior read is not completion.
- On completion, capture DacRegOut into RdData and go to Fin.
REQ-024 WaitR, timeout: if Cnt reaches RDTMO-1 without completion, go to Recover and set the internal timeout flag.
REQ-025 Recover: pulse DacRstCmd in its first cycle, hold for RSTWAIT cycles, then go to Fin.
REQ-026 Fin lasts 1 cycle:
- Pulse Done[g].
- Drive ErrOut=DacError, or ErrOut=0 if timed out.
- Drive Timeout = the timeout flag.
- Set Ptr=(g+1) mod 4, then go to Idle.
REQ-027 Ptr rotates only in Fin; it is not updated on Grant.
REQ-028 Boundary, simultaneous Reqs: exactly one Grant per transaction.
- Example: Ptr=2 with Req=4'b1011 grants requester 3.
REQ-029 Boundary, request timing:
- Req changes outside Idle are ignored.
- A Req dropped before Grant is lost with no Done.
REQ-030 Boundary, ReqData/ReqAddr changes after Grant do not affect the transaction in flight.
REQ-031 Boundary, rearbitration: at least one Idle cycle separates Fin from the next Grant.
REQ-032 Cnt saturates; it does not wrap.

Reset
REQ-033 Reset (any state, including mid-transaction): the block enters Idle next cycle with:
- Ptr=0, Cnt=0, SawLow=0, timeout flag=0.
- Outputs: Grant=0, Done=0, RdData=0, ErrOut=0, Timeout=0, Busy=0, DacStrobe=0, DacRead=0, DacRstCmd=0, DacReg=0, DacAddr=0.
- No Done is emitted for the aborted transaction.

Verification
REQ-034 Scenario, single write: Req=0001, ReqRead=0, data 16'h0ABC, addr 7'h0C.
- Required: Grant[0] pulse; DacStrobe pulse one cycle later with DacReg=0ABC and DacAddr=0C.
- Required: Done[0] exactly WRWAIT+2 cycles after Grant.
REQ-035 Scenario, read: requester 2 reads; loader model drops DacStrobeOut for 1000 cycles, then raises it with DacRegOut=16'h1234.
- Required: Done[2] with RdData=1234, Timeout=0.
REQ-036 Scenario, read with stale strobe: DacStrobeOut is high before Issue and never goes low.
- Required: no completion; after RDTMO cycles, a DacRstCmd pulse.
- Required: after RSTWAIT cycles, Done with Timeout=1 and ErrOut=0.
REQ-037 Scenario, fairness: all four Req held high continuously.
- Required: grants in order 0,1,2,3,0, each Done preceding the next Grant.
REQ-038 Scenario, reset mid-write: assert Reset during WaitW.
- Required: Busy=0 next cycle, no Done, and a new Req=0100 is granted to requester 2 (Ptr=0 search).
REQ-039 Scenario, error capture: write completes with DacError=2'b10.
- Required: ErrOut=10 with the Done pulse.
